// File: rtl/jstk_poll_sched.sv
// Joystick SPI transaction scheduler: starts 5-byte exchanges on a poll timer or
// on request, handshakes with the SPI byte controller and decodes X/Y/buttons.
module jstk_poll_sched #(
   parameter int unsigned POLL_PERIOD = 667,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        en_i,
   input  logic        req_i,
   input  logic [1:0]  led_i,
   input  logic        ss_i,
   input  logic [39:0] dout_i,
   output logic        snd_rec_o,
   output logic [39:0] din_o,
   output logic [9:0]  x_o,
   output logic [9:0]  y_o,
   output logic [2:0]  btn_o,
   output logic        valid_o,
   output logic        busy_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, START, XFER, RELEASE} state_t;

   localparam logic [15:0] TMR_RELOAD = 16'(POLL_PERIOD - 1);
   localparam logic [15:0] WCNT_MAX   = 16'(TIMEOUT - 1);

   state_t      state, state_d;
   logic [15:0] tmr;
   logic [15:0] wcnt;
   logic        pend;
   logic        rel_cnt;
   logic        trigger, capture, abort, wait_hit;
   logic        unused_dout;

   // Only the position and button bits of the received word are decoded.
   assign unused_dout = ^{dout_i[31:26], dout_i[15:10], dout_i[7:3]};

   assign snd_rec_o = (state == START) || (state == XFER);
   assign busy_o    = (state != IDLE);
   assign wait_hit  = (wcnt == WCNT_MAX);

   always_comb begin
      state_d = state;
      trigger = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            if ((en_i && (tmr == '0)) || req_i || pend) begin
               trigger = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (!ss_i) begin
               state_d = XFER;
            end else if (wait_hit) begin
               abort   = 1'b1;
               state_d = RELEASE;
            end
         end
         XFER: begin
            if (ss_i) begin
               capture = 1'b1;
               state_d = RELEASE;
            end else if (wait_hit) begin
               abort   = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (rel_cnt) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         din_o     <= '0;
         x_o       <= '0;
         y_o       <= '0;
         btn_o     <= '0;
         valid_o   <= 1'b0;
         timeout_o <= 1'b0;
         tmr       <= TMR_RELOAD;
         pend      <= 1'b0;
         wcnt      <= '0;
         rel_cnt   <= 1'b0;
      end else begin
         valid_o   <= capture;
         timeout_o <= abort;

         if (trigger) din_o <= {6'b100000, led_i, 32'h0};

         if (capture) begin
            x_o   <= {dout_i[25:24], dout_i[39:32]};
            y_o   <= {dout_i[9:8], dout_i[23:16]};
            btn_o <= dout_i[2:0];
         end

         if (trigger)                   tmr <= TMR_RELOAD;
         else if (en_i && (tmr != '0))  tmr <= tmr - 16'd1;

         // A request while IDLE is itself a trigger, so only non-IDLE requests latch.
         if (trigger)                       pend <= 1'b0;
         else if (req_i && (state != IDLE)) pend <= 1'b1;

         if (trigger || ((state == START) && !ss_i))
            wcnt <= '0;
         else if (((state == START) || (state == XFER)) && !wait_hit)
            wcnt <= wcnt + 16'd1;

         if (state == RELEASE) rel_cnt <= ~rel_cnt;
         else                  rel_cnt <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Self-checking bench for jstk_poll_sched with a behavioural SPI byte controller.
module tb_jstk_poll_sched;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        en_i;
   logic        req_i;
   logic [1:0]  led_i;
   logic        ss_i;
   logic [39:0] dout_i;
   logic        snd_rec_o;
   logic [39:0] din_o;
   logic [9:0]  x_o, y_o;
   logic [2:0]  btn_o;
   logic        valid_o, busy_o, timeout_o;

   jstk_poll_sched #(.POLL_PERIOD(20), .TIMEOUT(8)) dut (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .req_i(req_i), .led_i(led_i),
      .ss_i(ss_i), .dout_i(dout_i), .snd_rec_o(snd_rec_o), .din_o(din_o),
      .x_o(x_o), .y_o(y_o), .btn_o(btn_o), .valid_o(valid_o), .busy_o(busy_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Controller model: SS falls 2 negedges after sndRec, rises 4 later with DOUT.
   logic        model_en;
   logic [39:0] model_dout;
   int          mst, mcnt;
   always @(negedge clk or posedge reset_i) begin
      if (reset_i) begin
         ss_i <= 1'b1; mst <= 0; mcnt <= 0;
      end else begin
         case (mst)
            0: if (model_en && snd_rec_o) begin
                  if (mcnt == 1) begin ss_i <= 1'b0; mst <= 1; mcnt <= 0; end
                  else mcnt <= mcnt + 1;
               end else mcnt <= 0;
            1: if (mcnt == 3) begin ss_i <= 1'b1; dout_i <= model_dout; mst <= 2; end
               else mcnt <= mcnt + 1;
            default: if (!snd_rec_o) begin mst <= 0; mcnt <= 0; end
         endcase
      end
   end

   int   rise_cnt = 0, valid_cnt = 0, tmo_cnt = 0;
   logic prev_snd = 1'b0;
   always @(negedge clk) begin
      prev_snd <= snd_rec_o;
      if (snd_rec_o && !prev_snd) rise_cnt <= rise_cnt + 1;
      if (valid_o) valid_cnt <= valid_cnt + 1;
      if (timeout_o) tmo_cnt <= tmo_cnt + 1;
   end

   typedef struct {
      logic [39:0] dout;
      logic [1:0]  led;
      logic [39:0] din;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [2:0]  btn;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL global_time_limit actual=expired required=done");
      $fatal(1, "time limit");
   end

   initial begin
      int   k, r0, v0, t0;
      logic got, p;

      vecs[0] = '{40'hA5_03_3C_02_05, 2'b10, 40'h82_00000000, 10'h3A5, 10'h23C, 3'b101};
      vecs[1] = '{40'h00_00_00_00_00, 2'b00, 40'h80_00000000, 10'h000, 10'h000, 3'b000};
      vecs[2] = '{40'hFF_FF_FF_FF_FF, 2'b11, 40'h83_00000000, 10'h3FF, 10'h3FF, 3'b111};
      vecs[3] = '{40'h12_02_34_01_06, 2'b01, 40'h81_00000000, 10'h212, 10'h134, 3'b110};
      vecs[4] = '{40'h7E_FC_81_FD_F8, 2'b10, 40'h82_00000000, 10'h07E, 10'h181, 3'b000};

      reset_i = 1'b1; en_i = 1'b1; req_i = 1'b0; led_i = 2'b10;
      model_en = 1'b1; model_dout = vecs[0].dout; dout_i = '0;
      repeat (3) @(negedge clk);
      check("rst_snd_rec", snd_rec_o, 0);
      check("rst_din", din_o, 0);
      check("rst_x", x_o, 0);
      check("rst_y", y_o, 0);
      check("rst_btn", btn_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_timeout", timeout_o, 0);
      check("rst_busy", busy_o, 0);
      reset_i = 1'b0;

      // First automatic poll 20 cycles after reset release.
      for (k = 1; k <= 40; k++) begin @(negedge clk); if (snd_rec_o) break; end
      check("first_poll_delay", k, 20);
      p = 1'b1;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (snd_rec_o && !p) break;
         p = snd_rec_o;
      end
      check("poll_period", k, 20);
      check("poll_x", x_o, vecs[0].x);

      // Timer expiry and request in the same IDLE cycle.
      repeat (19) @(negedge clk);
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      check("sim_start", snd_rec_o, 1);
      #1 r0 = rise_cnt;
      repeat (19) @(negedge clk);
      #1 check("sim_no_followup", rise_cnt - r0, 0);
      check("sim_pend", dut.pend, 0);
      @(negedge clk);
      check("sim_next_timer_poll", snd_rec_o, 1);

      en_i = 1'b0;
      for (k = 0; k < 40 && busy_o; k++) @(negedge clk);
      check("idle_after_en_off", busy_o, 0);

      // Decode vectors, each run as an on-demand poll.
      for (int i = 0; i < 5; i++) begin
         led_i = vecs[i].led;
         model_dout = vecs[i].dout;
         repeat (2) @(negedge clk);
         req_i = 1'b1;
         @(negedge clk);
         req_i = 1'b0;
         got = 1'b0;
         for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (valid_o) begin got = 1'b1; break; end
         end
         check("vec_valid_seen", got, 1);
         if (got) begin
            check("vec_din", din_o, vecs[i].din);
            check("vec_x", x_o, vecs[i].x);
            check("vec_y", y_o, vecs[i].y);
            check("vec_btn", btn_o, vecs[i].btn);
            @(negedge clk);
            check("vec_valid_single", valid_o, 0);
         end
         for (k = 0; k < 40 && busy_o; k++) @(negedge clk);
         check("vec_idle", busy_o, 0);
      end

      // Three requests during one transaction collapse into one follow-up.
      #1 r0 = rise_cnt; v0 = valid_cnt;
      @(negedge clk);
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_i = 1'b1;
         @(negedge clk);
         req_i = 1'b0;
      end
      repeat (60) @(negedge clk);
      #1 check("pend_rises", rise_cnt - r0, 2);
      check("pend_valids", valid_cnt - v0, 2);
      check("pend_cleared", dut.pend, 0);

      // SS stuck high: abort after TIMEOUT cycles in START.
      model_en = 1'b0;
      t0 = tmo_cnt;
      @(negedge clk);
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      check("tmo_start", snd_rec_o, 1);
      repeat (7) @(negedge clk);
      check("tmo_snd_held", snd_rec_o, 1);
      check("tmo_not_yet", timeout_o, 0);
      @(negedge clk);
      check("tmo_snd_drop", snd_rec_o, 0);
      check("tmo_pulse", timeout_o, 1);
      check("tmo_busy_release", busy_o, 1);
      check("tmo_x_kept", x_o, vecs[4].x);
      check("tmo_y_kept", y_o, vecs[4].y);
      check("tmo_btn_kept", btn_o, vecs[4].btn);
      @(negedge clk);
      check("tmo_pulse_end", timeout_o, 0);
      check("tmo_busy_hold", busy_o, 1);
      @(negedge clk);
      check("tmo_busy_fall", busy_o, 0);
      #1 check("tmo_count", tmo_cnt - t0, 1);

      // Reset asserted while in XFER.
      model_en = 1'b1;
      @(negedge clk);
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      got = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!ss_i) begin got = 1'b1; break; end
      end
      check("xfer_reached", got, 1);
      @(posedge clk);
      #2 reset_i = 1'b1;
      #1;
      check("arst_snd_rec", snd_rec_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_x", x_o, 0);
      check("arst_y", y_o, 0);
      check("arst_btn", btn_o, 0);
      check("arst_din", din_o, 0);
      en_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      for (k = 1; k <= 40; k++) begin @(negedge clk); if (snd_rec_o) break; end
      check("resume_poll_delay", k, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
